vga_console_rgb332_quantizer: RTL and testbench

//  Reverse direction of the console 16-colour palette: maps an 8-bit RGB332 pixel to the
//  4-bit console colour index whose palette entry is nearest. Sits between pixel sources
//  (bitmap import, colour-picker logic) and the console text/attribute RAM writer.

---
 rtl/vga_console_pkg.sv | 16 +
 rtl/vga_console_rgb332_distance.sv | 18 +
 rtl/vga_console_rgb332_quantizer.sv | 67 ++++++
 tb/tb_vga_console_rgb332_quantizer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// vga_console_pkg: shared console palette, colour-index width and RGB332 field slices
package vga_console_pkg;
  localparam int COLOR_W = 4;
  localparam int N_COLORS = 16;
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;
  localparam logic [7:0] PALETTE [N_COLORS] = '{
    8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;
endpackage

// File: rtl/vga_console_rgb332_distance.sv
// vga_console_rgb332_distance: weighted L1 distance between two RGB332 colours, blue counted twice
module vga_console_rgb332_distance
  import vga_console_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [4:0] d_o
);
  logic [2:0] dr, dg;
  logic [1:0] db;
  // per-channel absolute differences summed into a 0..20 distance
  always_comb begin
    dr = a_i[R_HI:R_LO] > b_i[R_HI:R_LO] ? a_i[R_HI:R_LO] - b_i[R_HI:R_LO] : b_i[R_HI:R_LO] - a_i[R_HI:R_LO];
    dg = a_i[G_HI:G_LO] > b_i[G_HI:G_LO] ? a_i[G_HI:G_LO] - b_i[G_HI:G_LO] : b_i[G_HI:G_LO] - a_i[G_HI:G_LO];
    db = a_i[B_HI:B_LO] > b_i[B_HI:B_LO] ? a_i[B_HI:B_LO] - b_i[B_HI:B_LO] : b_i[B_HI:B_LO] - a_i[B_HI:B_LO];
    d_o = {2'b00, dr} + {2'b00, dg} + {2'b00, db, 1'b0};
  end
endmodule

// File: rtl/vga_console_rgb332_quantizer.sv
// vga_console_rgb332_quantizer: sequential nearest-palette search mapping RGB332 to a console colour index
module vga_console_rgb332_quantizer
  import vga_console_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_rgb332,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLOR_W-1:0] out_color_idx,
  output logic               out_exact
);
  state_e state_q, state_d;
  logic [7:0] pix_q, pix_d;
  logic [COLOR_W-1:0] idx_q, idx_d, best_idx_q, best_idx_d;
  logic [4:0] best_d_q, best_d_d, d;
  vga_console_rgb332_distance u_dist (.a_i(pix_q), .b_i(PALETTE[idx_q]), .d_o(d));
  assign in_ready = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_color_idx = best_idx_q;
  assign out_exact = best_d_q == 5'd0;
  // next state: latch pixel, walk the palette keeping the strictly-closer entry, hold result until taken
  always_comb begin
    state_d = state_q;
    pix_d = pix_q;
    idx_d = idx_q;
    best_idx_d = best_idx_q;
    best_d_d = best_d_q;
    case (state_q)
      IDLE: if (in_valid) begin
        pix_d = in_rgb332;
        idx_d = '0;
        best_d_d = 5'd31;
        best_idx_d = '0;
        state_d = SEARCH;
      end
      SEARCH: begin
        best_d_d = d < best_d_q ? d : best_d_q;
        best_idx_d = d < best_d_q ? idx_q : best_idx_q;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == '1 || (EARLY_EXIT && d == 5'd0)) ? DONE : SEARCH;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; best distance resets high so out_exact reads 0 out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pix_q <= '0;
      idx_q <= '0;
      best_idx_q <= '0;
      best_d_q <= 5'd31;
    end else begin
      state_q <= state_d;
      pix_q <= pix_d;
      idx_q <= idx_d;
      best_idx_q <= best_idx_d;
      best_d_q <= best_d_d;
    end
  end
endmodule

// File: tb/tb_vga_console_rgb332_quantizer.sv
// tb_vga_console_rgb332_quantizer: scoreboard bench for both early-exit settings of the quantiser
module tb_vga_console_rgb332_quantizer;
  typedef struct {logic [3:0] idx; logic ex; int lat;} exp_t;
  logic clk, rst_n;
  logic [1:0] iv, ir, ov, ordy, ex;
  logic [7:0] pix [2];
  logic [3:0] cidx [2];
  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  vga_console_rgb332_quantizer #(.EARLY_EXIT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_rgb332(pix[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_color_idx(cidx[0]), .out_exact(ex[0]));
  vga_console_rgb332_quantizer #(.EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_rgb332(pix[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_color_idx(cidx[1]), .out_exact(ex[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int absd(input int a, input int b);
    return a > b ? a - b : b - a;
  endfunction

  function automatic exp_t model(input logic [7:0] p, input bit ee);
    exp_t e;
    logic [7:0] c;
    int best, d;
    bit found;
    best = 31;
    found = 0;
    e.idx = 0;
    e.lat = 16;
    for (int i = 0; i < 16; i++) begin
      c = (i == 0) ? 8'hFF : 8'h00;
      d = absd(int'(p[7:5]), int'(c[7:5])) + absd(int'(p[4:2]), int'(c[4:2])) + 2 * absd(int'(p[1:0]), int'(c[1:0]));
      if (d < best) begin
        best = d;
        e.idx = 4'(i);
      end
      if (ee && d == 0 && !found) begin
        found = 1;
        e.lat = i + 1;
      end
    end
    e.ex = (best == 0);
    return e;
  endfunction

  task automatic send(input int s, input logic [7:0] p);
    int n = 0;
    @(negedge clk);
    while (!ir[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[s]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut=%0d in_ready=%b required=1", s, ir[s]);
    end
    iv[s] = 1'b1;
    pix[s] = p;
    @(posedge clk);
    #1 iv[s] = 1'b0;
    sbq.push_back(model(p, s == 0));
  endtask

  task automatic wait_valid(input int s, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov[s]) break;
    end
    if (!ov[s]) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout dut=%0d out_valid=%b required=1", s, ov[s]);
    end
  endtask

  task automatic ack(input int s);
    ordy[s] = 1'b1;
    @(posedge clk);
    #1 ordy[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    pix[0] = '0;
    pix[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({ir[s], ov[s], cidx[s], ex[s]} !== 7'b0) begin
        failures++;
        $display("FAIL reset_state dut=%0d ready/valid/idx/exact=%b/%b/%0d/%b required 0/0/0/0", s, ir[s], ov[s], cidx[s], ex[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ir !== 2'b11) begin
      failures++;
      $display("FAIL reset_release_ready in_ready=%b required=11", ir);
    end
  endtask

  task automatic test_table;
    logic [7:0] tbl [5];
    exp_t e;
    int lat;
    tbl = '{8'hFF, 8'h00, 8'hE0, 8'hFC, 8'hB4};
    for (int i = 0; i < 5; i++) begin
      send(0, tbl[i]);
      wait_valid(0, lat);
      e = sbq.pop_front();
      checks += 3;
      if (cidx[0] !== e.idx) begin failures++; $display("FAIL table_idx pix=%h got=%0d required=%0d", tbl[i], cidx[0], e.idx); end
      if (ex[0] !== e.ex) begin failures++; $display("FAIL table_exact pix=%h got=%b required=%b", tbl[i], ex[0], e.ex); end
      if (lat != e.lat) begin failures++; $display("FAIL table_latency pix=%h got=%0d required=%0d", tbl[i], lat, e.lat); end
      ack(0);
    end
  endtask

  task automatic test_no_early_exit;
    logic [7:0] tbl [4];
    exp_t e;
    int lat;
    tbl = '{8'h00, 8'hFF, 8'hE0, 8'hB4};
    for (int i = 0; i < 4; i++) begin
      send(1, tbl[i]);
      wait_valid(1, lat);
      e = sbq.pop_front();
      checks += 3;
      if (cidx[1] !== e.idx) begin failures++; $display("FAIL full_idx pix=%h got=%0d required=%0d", tbl[i], cidx[1], e.idx); end
      if (ex[1] !== e.ex) begin failures++; $display("FAIL full_exact pix=%h got=%b required=%b", tbl[i], ex[1], e.ex); end
      if (lat != e.lat) begin failures++; $display("FAIL full_latency pix=%h got=%0d required=%0d", tbl[i], lat, e.lat); end
      ack(1);
    end
  endtask

  task automatic test_back_pressure;
    exp_t e;
    int lat;
    int bad = 0;
    send(0, 8'hE0);
    wait_valid(0, lat);
    e = sbq.pop_front();
    repeat (20) begin
      @(negedge clk);
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || cidx[0] !== e.idx || ex[0] !== e.ex) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable bad_cycles=%0d required=0 idx=%0d/%0d exact=%b/%b", bad, cidx[0], e.idx, ex[0], e.ex);
    end
    ack(0);
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL release out_valid=%b in_ready=%b required 0/1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid_search;
    exp_t e;
    int lat;
    int bad = 0;
    send(0, 8'hE0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ir !== 2'b00) begin
      failures++;
      $display("FAIL ready_in_reset in_ready=%b required=00", ir);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    e = sbq.pop_back();
    repeat (20) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL dropped_pixel bad_cycles=%0d required=0 idx_dropped=%0d", bad, e.idx);
    end
    send(0, 8'hFF);
    wait_valid(0, lat);
    e = sbq.pop_front();
    checks += 2;
    if (cidx[0] !== e.idx || ex[0] !== e.ex) begin failures++; $display("FAIL post_reset_result idx=%0d exact=%b required %0d/%b", cidx[0], ex[0], e.idx, e.ex); end
    if (lat != e.lat) begin failures++; $display("FAIL post_reset_latency got=%0d required=%0d", lat, e.lat); end
    ack(0);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    logic [7:0] p;
    for (int i = 0; i < 12; i++) begin
      int s = i % 2;
      p = (i % 4 == 0) ? ((i % 8 == 0) ? 8'hFF : 8'h00) : 8'($urandom_range(0, 255));
      send(s, p);
      wait_valid(s, lat);
      e = sbq.pop_front();
      checks += 3;
      if (cidx[s] !== e.idx) begin failures++; $display("FAIL b2b_idx dut=%0d pix=%h got=%0d required=%0d", s, p, cidx[s], e.idx); end
      if (ex[s] !== e.ex) begin failures++; $display("FAIL b2b_exact dut=%0d pix=%h got=%b required=%b", s, p, ex[s], e.ex); end
      if (lat != e.lat) begin failures++; $display("FAIL b2b_latency dut=%0d pix=%h got=%0d required=%0d", s, p, lat, e.lat); end
      ack(s);
    end
  endtask

  initial begin
    test_reset;
    test_table;
    test_no_early_exit;
    test_back_pressure;
    test_reset_mid_search;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required_finish_before=500000", $time);
    $fatal(1);
  end
endmodule
